// File: rtl/decode_stage.sv
// decode_stage
//   RV32I instruction decode with an ID/EX pipeline register.
//   Decodes the fetched word combinationally, reads both source operands from
//   the register file (with same-cycle write-back bypass) and captures a
//   decoded bundle that is handed to execute over a valid/ready handshake.
//
// Ports
//   clk, reset_n                    clock (rising edge), async active-low reset
//   if_valid_i/if_instr_i/if_pc_i   instruction offered by fetch
//   if_ready_o                      decode accepts this cycle
//   rf_rs1_addr_o/rf_rs2_addr_o     register-file read addresses (raw fields)
//   rf_rs1_i/rf_rs2_i               combinational register-file read data
//   wb_enable_i/wb_addr_i/wb_data_i copy of the register-file write port
//   flush_i                         kill held and incoming instruction
//   ex_ready_i                      execute accepts the bundle
//   ex_*                            registered decoded bundle
module decode_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            if_valid_i,
  input  logic [31:0]     if_instr_i,
  input  logic [XLEN-1:0] if_pc_i,
  output logic            if_ready_o,
  output logic [4:0]      rf_rs1_addr_o,
  output logic [4:0]      rf_rs2_addr_o,
  input  logic [XLEN-1:0] rf_rs1_i,
  input  logic [XLEN-1:0] rf_rs2_i,
  input  logic            wb_enable_i,
  input  logic [4:0]      wb_addr_i,
  input  logic [XLEN-1:0] wb_data_i,
  input  logic            flush_i,
  input  logic            ex_ready_i,
  output logic            ex_valid_o,
  output logic [XLEN-1:0] ex_pc_o,
  output logic [XLEN-1:0] ex_rs1_data_o,
  output logic [XLEN-1:0] ex_rs2_data_o,
  output logic [XLEN-1:0] ex_imm_o,
  output logic [4:0]      ex_rd_addr_o,
  output logic [4:0]      ex_rs1_addr_o,
  output logic [4:0]      ex_rs2_addr_o,
  output logic [3:0]      ex_class_o,
  output logic [2:0]      ex_funct3_o,
  output logic            ex_funct7b5_o,
  output logic            ex_illegal_o
);

  typedef enum logic [3:0] {
    CLS_OP      = 4'd0,
    CLS_OP_IMM  = 4'd1,
    CLS_LOAD    = 4'd2,
    CLS_STORE   = 4'd3,
    CLS_BRANCH  = 4'd4,
    CLS_JAL     = 4'd5,
    CLS_JALR    = 4'd6,
    CLS_LUI     = 4'd7,
    CLS_AUIPC   = 4'd8,
    CLS_FENCE   = 4'd9,
    CLS_SYSTEM  = 4'd10,
    CLS_ILLEGAL = 4'd15
  } class_t;

  typedef enum logic [2:0] {
    IMM_NONE,
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J
  } imm_t;

  class_t          cls;
  imm_t            imm_sel;
  logic [31:0]     imm;
  logic            use_rs1;
  logic            use_rs2;
  logic            use_rd;
  logic [4:0]      dec_rs1;
  logic [4:0]      dec_rs2;
  logic [4:0]      dec_rd;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic            load;
  logic            hit_rs1;
  logic            hit_rs2;

  assign rf_rs1_addr_o = if_instr_i[19:15];
  assign rf_rs2_addr_o = if_instr_i[24:20];

  assign if_ready_o = !ex_valid_o || ex_ready_i;
  assign load       = if_valid_i && if_ready_o;

  always_comb begin
    cls     = CLS_ILLEGAL;
    imm_sel = IMM_NONE;
    if (if_instr_i[1:0] == 2'b11) begin
      case (if_instr_i[6:2])
        5'b01100: cls = CLS_OP;
        5'b00100: begin cls = CLS_OP_IMM; imm_sel = IMM_I; end
        5'b00000: begin cls = CLS_LOAD;   imm_sel = IMM_I; end
        5'b01000: begin cls = CLS_STORE;  imm_sel = IMM_S; end
        5'b11000: begin cls = CLS_BRANCH; imm_sel = IMM_B; end
        5'b11011: begin cls = CLS_JAL;    imm_sel = IMM_J; end
        5'b11001: begin cls = CLS_JALR;   imm_sel = IMM_I; end
        5'b01101: begin cls = CLS_LUI;    imm_sel = IMM_U; end
        5'b00101: begin cls = CLS_AUIPC;  imm_sel = IMM_U; end
        5'b00011: begin cls = CLS_FENCE;  imm_sel = IMM_I; end
        5'b11100: begin cls = CLS_SYSTEM; imm_sel = IMM_I; end
        default:  ;
      endcase
    end
  end

  always_comb begin
    imm = '0;
    case (imm_sel)
      IMM_I: imm = {{20{if_instr_i[31]}}, if_instr_i[31:20]};
      IMM_S: imm = {{20{if_instr_i[31]}}, if_instr_i[31:25], if_instr_i[11:7]};
      IMM_B: imm = {{19{if_instr_i[31]}}, if_instr_i[31], if_instr_i[7],
                    if_instr_i[30:25], if_instr_i[11:8], 1'b0};
      IMM_U: imm = {if_instr_i[31:12], 12'b0};
      IMM_J: imm = {{11{if_instr_i[31]}}, if_instr_i[31], if_instr_i[19:12],
                    if_instr_i[20], if_instr_i[30:21], 1'b0};
      default: imm = '0;
    endcase
  end

  // Unused operands are forced to x0 so execute's hazard logic never sees
  // a false dependency on an immediate field.
  assign use_rs1 = !(cls inside {CLS_LUI, CLS_AUIPC, CLS_JAL, CLS_ILLEGAL});
  assign use_rs2 = cls inside {CLS_OP, CLS_STORE, CLS_BRANCH};
  assign use_rd  = !(cls inside {CLS_STORE, CLS_BRANCH, CLS_FENCE, CLS_ILLEGAL});

  assign dec_rs1 = use_rs1 ? if_instr_i[19:15] : 5'd0;
  assign dec_rs2 = use_rs2 ? if_instr_i[24:20] : 5'd0;
  assign dec_rd  = use_rd  ? if_instr_i[11:7]  : 5'd0;

  // A nonzero address match already implies wb_addr_i != 0.
  always_comb begin
    rs1_data = '0;
    rs2_data = '0;
    if (dec_rs1 != 5'd0)
      rs1_data = (wb_enable_i && (wb_addr_i == dec_rs1)) ? wb_data_i : rf_rs1_i;
    if (dec_rs2 != 5'd0)
      rs2_data = (wb_enable_i && (wb_addr_i == dec_rs2)) ? wb_data_i : rf_rs2_i;
  end

  assign hit_rs1 = wb_enable_i && (wb_addr_i != 5'd0) && (wb_addr_i == ex_rs1_addr_o);
  assign hit_rs2 = wb_enable_i && (wb_addr_i != 5'd0) && (wb_addr_i == ex_rs2_addr_o);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ex_valid_o    <= 1'b0;
      ex_pc_o       <= '0;
      ex_rs1_data_o <= '0;
      ex_rs2_data_o <= '0;
      ex_imm_o      <= '0;
      ex_rd_addr_o  <= '0;
      ex_rs1_addr_o <= '0;
      ex_rs2_addr_o <= '0;
      ex_class_o    <= '0;
      ex_funct3_o   <= '0;
      ex_funct7b5_o <= 1'b0;
      ex_illegal_o  <= 1'b0;
    end else if (flush_i) begin
      ex_valid_o <= 1'b0;
    end else if (load) begin
      ex_valid_o    <= 1'b1;
      ex_pc_o       <= if_pc_i;
      ex_rs1_data_o <= rs1_data;
      ex_rs2_data_o <= rs2_data;
      ex_imm_o      <= imm;
      ex_rd_addr_o  <= dec_rd;
      ex_rs1_addr_o <= dec_rs1;
      ex_rs2_addr_o <= dec_rs2;
      ex_class_o    <= cls;
      ex_funct3_o   <= if_instr_i[14:12];
      ex_funct7b5_o <= if_instr_i[30];
      ex_illegal_o  <= (cls == CLS_ILLEGAL);
    end else if (if_ready_o) begin
      // ready but nothing offered: drain to a bubble
      ex_valid_o <= 1'b0;
    end else begin
      // holding for execute: keep operands coherent with the register file
      if (hit_rs1) ex_rs1_data_o <= wb_data_i;
      if (hit_rs2) ex_rs2_data_o <= wb_data_i;
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
module tb_decode_stage;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] rs1d;
    logic [31:0] rs2d;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [3:0]  cls;
    logic [2:0]  f3;
    logic        f7;
    logic        ill;
  } bundle_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        if_ready;
  logic [4:0]  rf_rs1_addr;
  logic [4:0]  rf_rs2_addr;
  logic [31:0] rf_rs1;
  logic [31:0] rf_rs2;
  logic        wb_enable;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        flush;
  logic        ex_ready;
  logic        ex_valid;
  logic [31:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
  logic [4:0]  ex_rd_addr, ex_rs1_addr, ex_rs2_addr;
  logic [3:0]  ex_class;
  logic [2:0]  ex_funct3;
  logic        ex_funct7b5;
  logic        ex_illegal;

  logic [31:0] regs [32];
  bundle_t     exp_b;
  logic        exp_v;
  logic        last_stall;
  int          tests = 0;
  int          fails = 0;

  always #5 clk = ~clk;

  assign rf_rs1 = regs[if_instr[19:15]];
  assign rf_rs2 = regs[if_instr[24:20]];

  decode_stage #(.XLEN(32)) dut (
    .clk(clk), .reset_n(reset_n),
    .if_valid_i(if_valid), .if_instr_i(if_instr), .if_pc_i(if_pc),
    .if_ready_o(if_ready),
    .rf_rs1_addr_o(rf_rs1_addr), .rf_rs2_addr_o(rf_rs2_addr),
    .rf_rs1_i(rf_rs1), .rf_rs2_i(rf_rs2),
    .wb_enable_i(wb_enable), .wb_addr_i(wb_addr), .wb_data_i(wb_data),
    .flush_i(flush), .ex_ready_i(ex_ready),
    .ex_valid_o(ex_valid), .ex_pc_o(ex_pc),
    .ex_rs1_data_o(ex_rs1_data), .ex_rs2_data_o(ex_rs2_data), .ex_imm_o(ex_imm),
    .ex_rd_addr_o(ex_rd_addr), .ex_rs1_addr_o(ex_rs1_addr), .ex_rs2_addr_o(ex_rs2_addr),
    .ex_class_o(ex_class), .ex_funct3_o(ex_funct3), .ex_funct7b5_o(ex_funct7b5),
    .ex_illegal_o(ex_illegal)
  );

  // Reference decode: class from the opcode table, immediate by format letter,
  // operand values from the bench's register array with write-back forwarding.
  function automatic bundle_t ref_decode(input logic [31:0] w, input logic [31:0] pc);
    bundle_t b;
    byte fmt;
    logic u1, u2, ud;
    logic [31:0] sx;
    b   = '0;
    fmt = "R";
    sx  = w[31] ? 32'hFFFF_FFFF : 32'h0;
    b.cls = 4'd15;
    if (w[1:0] == 2'b11) begin
      case (w[6:0])
        7'h33: begin b.cls = 4'd0;  fmt = "R"; end
        7'h13: begin b.cls = 4'd1;  fmt = "I"; end
        7'h03: begin b.cls = 4'd2;  fmt = "I"; end
        7'h23: begin b.cls = 4'd3;  fmt = "S"; end
        7'h63: begin b.cls = 4'd4;  fmt = "B"; end
        7'h6F: begin b.cls = 4'd5;  fmt = "J"; end
        7'h67: begin b.cls = 4'd6;  fmt = "I"; end
        7'h37: begin b.cls = 4'd7;  fmt = "U"; end
        7'h17: begin b.cls = 4'd8;  fmt = "U"; end
        7'h0F: begin b.cls = 4'd9;  fmt = "I"; end
        7'h73: begin b.cls = 4'd10; fmt = "I"; end
        default: b.cls = 4'd15;
      endcase
    end
    if (b.cls == 4'd15) fmt = "R";
    case (fmt)
      "I": b.imm = (sx << 12) | 32'(w[31:20]);
      "S": b.imm = (sx << 12) | 32'({w[31:25], w[11:7]});
      "B": b.imm = (sx << 13) | 32'({w[31], w[7], w[30:25], w[11:8], 1'b0});
      "U": b.imm = w & 32'hFFFF_F000;
      "J": b.imm = (sx << 21) | 32'({w[31], w[19:12], w[20], w[30:21], 1'b0});
      default: b.imm = 32'h0;
    endcase
    u1 = !(b.cls inside {4'd5, 4'd7, 4'd8, 4'd15});
    u2 = (b.cls inside {4'd0, 4'd3, 4'd4});
    ud = !(b.cls inside {4'd3, 4'd4, 4'd9, 4'd15});
    b.rs1  = u1 ? w[19:15] : 5'd0;
    b.rs2  = u2 ? w[24:20] : 5'd0;
    b.rd   = ud ? w[11:7]  : 5'd0;
    b.rs1d = read_op(b.rs1);
    b.rs2d = read_op(b.rs2);
    b.pc   = pc;
    b.f3   = w[14:12];
    b.f7   = w[30];
    b.ill  = (b.cls == 4'd15);
    return b;
  endfunction

  function automatic logic [31:0] read_op(input logic [4:0] a);
    if (a == 5'd0) return 32'h0;
    if (wb_enable && wb_addr == a) return wb_data;
    return regs[a];
  endfunction

  // Advance the model by one clock edge using the inputs that were present at it.
  task automatic model_step();
    logic rdy;
    rdy = !exp_v || ex_ready;
    last_stall = 1'b0;
    if (!reset_n) begin
      exp_b = '0;
      exp_v = 1'b0;
    end else if (flush) begin
      exp_v = 1'b0;
    end else if (if_valid && rdy) begin
      exp_b = ref_decode(if_instr, if_pc);
      exp_v = 1'b1;
    end else if (rdy) begin
      exp_v = 1'b0;
    end else begin
      last_stall = if_valid;
      if (wb_enable && wb_addr != 5'd0) begin
        if (wb_addr == exp_b.rs1) exp_b.rs1d = wb_data;
        if (wb_addr == exp_b.rs2) exp_b.rs2d = wb_data;
      end
    end
    if (reset_n && wb_enable && wb_addr != 5'd0) regs[wb_addr] = wb_data;
  endtask

  task automatic compare();
    bundle_t act;
    logic ok;
    act = '{pc: ex_pc, rs1d: ex_rs1_data, rs2d: ex_rs2_data, imm: ex_imm,
            rd: ex_rd_addr, rs1: ex_rs1_addr, rs2: ex_rs2_addr, cls: ex_class,
            f3: ex_funct3, f7: ex_funct7b5, ill: ex_illegal};
    ok = (ex_valid === exp_v) && (if_ready === (!exp_v || ex_ready)) &&
         (rf_rs1_addr === if_instr[19:15]) && (rf_rs2_addr === if_instr[24:20]);
    if (exp_v || !reset_n) ok = ok && (act === exp_b);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL cycle_compare t=%0t: got v=%b rdy=%b bundle=%h, want v=%b rdy=%b bundle=%h",
               $time, ex_valid, if_ready, act, exp_v, !exp_v || ex_ready, exp_b);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
    model_step();
    @(negedge clk);
    compare();
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    tests++;
    if (act !== want) begin
      fails++;
      $display("FAIL %s: got %h, want %h", name, act, want);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] w, input logic [31:0] pc,
                       input logic rdy, input logic fl,
                       input logic we, input logic [4:0] wa, input logic [31:0] wd);
    if_valid  = v;
    if_instr  = w;
    if_pc     = pc;
    ex_ready  = rdy;
    flush     = fl;
    wb_enable = we;
    wb_addr   = wa;
    wb_data   = wd;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [6:0] ops [11];
    logic [31:0] w;
    ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17, 7'h0F, 7'h73};
    w = $urandom;
    if ($urandom_range(0, 9) != 0) w[6:0] = ops[$urandom_range(0, 10)];
    if ($urandom_range(0, 3) != 0) begin
      w[19:15] = 5'($urandom_range(0, 7));
      w[24:20] = 5'($urandom_range(0, 7));
    end
    return w;
  endfunction

  initial begin
    for (int i = 0; i < 32; i++) regs[i] = $urandom;
    regs[0] = 32'hAAAA_AAAA;
    regs[3] = 32'h1111_1111;
    regs[6] = 32'h6666_6666;
    regs[7] = 32'h7777_7777;
    exp_b = '0;
    exp_v = 1'b0;
    last_stall = 1'b0;
    reset_n = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);

    #2;
    chk("reset_valid", 32'(ex_valid), 32'h0);
    chk("reset_ready", 32'(if_ready), 32'h1);
    chk("reset_class", 32'(ex_class), 32'h0);
    chk("reset_pc", ex_pc, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;

    // addi x5,x0,-1
    drive(1'b1, 32'hFFF0_0293, 32'h100, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
    cycle();
    chk("addi_valid", 32'(ex_valid), 32'h1);
    chk("addi_class", 32'(ex_class), 32'd1);
    chk("addi_rd", 32'(ex_rd_addr), 32'd5);
    chk("addi_rs1", 32'(ex_rs1_addr), 32'd0);
    chk("addi_rs1d", ex_rs1_data, 32'h0);
    chk("addi_imm", ex_imm, 32'hFFFF_FFFF);

    // add x1,x3,x3 with concurrent write-back of x3
    drive(1'b1, 32'h0031_80B3, 32'h104, 1'b1, 1'b0, 1'b1, 5'd3, 32'hDEAD_BEEF);
    cycle();
    chk("byp_rs1d", ex_rs1_data, 32'hDEAD_BEEF);
    chk("byp_rs2d", ex_rs2_data, 32'hDEAD_BEEF);
    chk("byp_class", 32'(ex_class), 32'd0);
    chk("byp_rd", 32'(ex_rd_addr), 32'd1);

    // beq x1,x2,-4
    drive(1'b1, 32'hFE20_8EE3, 32'h108, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
    cycle();
    chk("beq_class", 32'(ex_class), 32'd4);
    chk("beq_imm", ex_imm, 32'hFFFF_FFFC);
    chk("beq_rd", 32'(ex_rd_addr), 32'd0);

    // add x2,x0,x0 while x0 is "written" with 5
    drive(1'b1, 32'h0000_0133, 32'h10C, 1'b1, 1'b0, 1'b1, 5'd0, 32'h5);
    cycle();
    chk("x0_rs1d", ex_rs1_data, 32'h0);
    chk("x0_rs2d", ex_rs2_data, 32'h0);

    // add x1,x6,x7 then hold with a write-back of x7
    drive(1'b1, 32'h0073_00B3, 32'h200, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
    cycle();
    drive(1'b1, 32'h0000_0013, 32'h204, 1'b0, 1'b0, 1'b1, 5'd7, 32'h1234_5678);
    cycle();
    chk("hold_rs2d", ex_rs2_data, 32'h1234_5678);
    chk("hold_rs1d", ex_rs1_data, 32'h6666_6666);
    chk("hold_pc", ex_pc, 32'h200);
    chk("hold_rd", 32'(ex_rd_addr), 32'd1);
    chk("hold_ready", 32'(if_ready), 32'h0);

    // flush while holding with fetch valid
    drive(1'b1, 32'h0000_0013, 32'h204, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0);
    cycle();
    chk("flush_valid", 32'(ex_valid), 32'h0);
    chk("flush_ready", 32'(if_ready), 32'h1);
    drive(1'b1, 32'hFFF0_0293, 32'h300, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    cycle();
    chk("post_flush_valid", 32'(ex_valid), 32'h1);
    chk("post_flush_pc", ex_pc, 32'h300);

    // all-zero word is illegal
    drive(1'b1, 32'h0000_0000, 32'h400, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
    cycle();
    chk("ill_class", 32'(ex_class), 32'd15);
    chk("ill_flag", 32'(ex_illegal), 32'h1);
    chk("ill_addrs", 32'({ex_rd_addr, ex_rs1_addr, ex_rs2_addr}), 32'h0);

    // asynchronous reset in the middle of a cycle
    #2;
    reset_n = 1'b0;
    #1;
    chk("areset_valid", 32'(ex_valid), 32'h0);
    chk("areset_pc", ex_pc, 32'h0);
    chk("areset_class", 32'(ex_class), 32'h0);
    chk("areset_illegal", 32'(ex_illegal), 32'h0);
    chk("areset_ready", 32'(if_ready), 32'h1);
    exp_b = '0;
    exp_v = 1'b0;
    cycle();
    reset_n = 1'b1;
    drive(1'b1, 32'hFFF0_0293, 32'h500, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
    cycle();
    chk("first_load_valid", 32'(ex_valid), 32'h1);
    chk("first_load_pc", ex_pc, 32'h500);

    // randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      logic [4:0] wa;
      if (!last_stall) begin
        if_valid = ($urandom_range(0, 9) < 7);
        if_instr = rand_instr();
        if_pc    = $urandom & 32'hFFFF_FFFC;
      end
      ex_ready  = ($urandom_range(0, 9) < 7);
      flush     = ($urandom_range(0, 19) == 0);
      wb_enable = ($urandom_range(0, 1) == 1);
      case ($urandom_range(0, 4))
        0: wa = if_instr[19:15];
        1: wa = if_instr[24:20];
        2: wa = exp_b.rs1;
        3: wa = exp_b.rs2;
        default: wa = 5'($urandom);
      endcase
      wb_addr = wa;
      wb_data = $urandom;
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
# decode_stage

RV32I instruction-decode stage with an ID/EX pipeline register. It sits between fetch and execute and drives the register file's read-address ports (`rs1_addr_i`/`rs2_addr_i`). It captures `rs1_o`/`rs2_o`, with same-cycle write-back bypass. It emits a registered, valid/ready-handshaked decoded bundle to execute.

## Interface
- `XLEN`, 32: datapath width; fixed at 32.
- `clk`  in  1  single clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `if_valid_i`  in  1  fetch offers an instruction.
- `if_instr_i`  in  32  instruction word.
- `if_pc_i`  in  32  instruction PC.
- `if_ready_o`  out  1  decode accepts this cycle.
- `rf_rs1_addr_o` / `rf_rs2_addr_o`  out  5  to register file; equal to `if_instr_i[19:15]` / `[24:20]`.
- `rf_rs1_i` / `rf_rs2_i`  in  32  combinational read data from register file.
- `wb_enable_i`, `wb_addr_i[4:0]`, `wb_data_i[31:0]`  in  copy of the register-file write port.
- `flush_i`  in  1  kill the held and incoming instruction.
- `ex_ready_i`  in  1  execute accepts the bundle.
- `ex_valid_o`  out  1  bundle valid.
- `ex_pc_o`, `ex_rs1_data_o`, `ex_rs2_data_o`, `ex_imm_o`  out  32.
- `ex_rd_addr_o`, `ex_rs1_addr_o`, `ex_rs2_addr_o`  out  5.
- `ex_class_o`  out  4  opcode class.
- `ex_funct3_o`  out  3.
- `ex_funct7b5_o`  out  1  `instr[30]`.
- `ex_illegal_o`  out  1.

## Operation
- Class encoding:
  - Legal classes: OP=0, OP_IMM=1, LOAD=2, STORE=3, BRANCH=4, JAL=5, JALR=6, LUI=7, AUIPC=8, FENCE=9, SYSTEM=10.
  - ILLEGAL=15 for an unknown opcode or `instr[1:0]`≠2'b11.
  - For ILLEGAL: `ex_illegal_o`=1, and rd/rs1/rs2 addresses are 0.
- Immediates, all sign-extended from `instr[31]`:
  - I: OP_IMM, LOAD, JALR, SYSTEM, FENCE.
  - S: STORE.
  - B: BRANCH, bit 0 = 0.
  - U: LUI, AUIPC, low 12 bits = 0.
  - J: JAL, bit 0 = 0.
  - OP: imm = 0.
- Used-register masking on the captured addresses:
  - `ex_rs1_addr_o`=0 for LUI, AUIPC, JAL.
  - `ex_rs2_addr_o`=0 unless OP, STORE, BRANCH.
  - `ex_rd_addr_o`=0 for STORE, BRANCH, FENCE, ILLEGAL.
  - Data of a masked operand is captured as 0.
- Bypass: an operand value equals `wb_data_i` when `wb_enable_i` is high, `wb_addr_i`≠0, and `wb_addr_i` equals the source address. Otherwise it equals the register-file value.
- x0 reads always yield 0, regardless of `wb_*` or `rf_*`.
- Handshake:
  - `if_ready_o` = !`ex_valid_o` || `ex_ready_i`.
  - Load occurs when `if_valid_i` && `if_ready_o`.
  - A bundle transfers to execute when `ex_valid_o` && `ex_ready_i`.
- Hold refresh: while holding (`ex_valid_o`=1, `ex_ready_i`=0), a write-back to nonzero `ex_rs1_addr_o`/`ex_rs2_addr_o` updates the corresponding held data register. No other held field changes.
- Priority per cycle: reset > flush > load > hold-refresh > retain.

## Timing
- Reset: all `ex_*` outputs are 0 (including `ex_valid_o`, `ex_class_o`, `ex_illegal_o`), asserted immediately on reset, asynchronous.
- `if_ready_o`=1 during reset and after reset.
- Latency: fetch handshake at edge N gives the bundle valid after edge N; one cycle total.
- Throughput: one instruction per cycle while `ex_ready_i`=1.
- Fetch valid without handshake (`if_valid_i`=1, `if_ready_o`=0): `if_instr_i` is not sampled. Fetch must hold it stable.
- Fetch idle: `if_valid_i`=0 with `if_ready_o`=1 means `ex_valid_o` falls after the edge. This inserts a bubble.
- `flush_i` at edge N: `ex_valid_o`=0 after N.
  - Any handshake in that cycle is consumed and discarded.
  - `if_ready_o` is unaffected by `flush_i`.
- Bypass and refresh use the write-back value present at the same edge as the register-file write. There is no stale window.
- Reset deasserted mid-stream: the first load is possible at the first edge with `reset_n`=1.

## Test plan
- **ADDI decode:** `addi x5,x0,-1` (0xFFF00293), `ex_ready_i`=1 -> next cycle: `ex_valid_o`=1, class=1, rd=5, `ex_rs1_addr_o`=0, `ex_rs1_data_o`=0, imm=0xFFFFFFFF.
- **Same-cycle bypass:**
  - Setup: x3 holds 0x11111111; write-back writes x3=0xDEADBEEF in the same cycle `add x1,x3,x3` (0x003180B3) loads.
  - Required: `ex_rs1_data_o`=`ex_rs2_data_o`=0xDEADBEEF, class=0, rd=1.
- **Branch immediate and x0 masking:**
  - `beq x1,x2,-4` (0xFE208EE3) -> class=4, imm=0xFFFFFFFC, `ex_rd_addr_o`=0.
  - Write-back writing x0=0x5 concurrently with an instruction reading x0 -> operand stays 0.
- **Hold refresh:**
  - Setup: a held bundle with rs2=x7, `ex_ready_i`=0; write-back writes x7=0x12345678.
  - Required next cycle: `ex_rs2_data_o`=0x12345678, all other fields unchanged, `if_ready_o`=0, and a presented `if_instr_i` is not captured.
- **Flush:** `flush_i`=1 with `ex_valid_o`=1, `ex_ready_i`=0, `if_valid_i`=1 -> `ex_valid_o`=0 next cycle; the following valid instruction loads normally.
- **Illegal and async reset:**
  - 0x00000000 -> class=15, `ex_illegal_o`=1, all addresses 0.
  - `reset_n` dropped mid-cycle while `ex_valid_o`=1 -> `ex_valid_o`=0 and all `ex_*`=0 without waiting for `clk`.
